// File: rtl/prescale_period_meter.sv
// rtl/prescale_period_meter.sv - averaged period meter for the prescaler output
//
// Purpose: synchronises the asynchronous prescaler square wave, measures the
// spacing of its rising edges in clk cycles, averages 2^AVG_LOG2 spacings and
// presents the result through a valid/ack handshake.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   prescaled    prescaler output, asynchronous to clk
//   enable       measurement enable
//   periodAck    consumer acknowledges period
//   period       averaged period in clocks (CNT_W bits)
//   periodValid  period holds an unacknowledged result
//   overrun      sticky: a result was overwritten before being acked
//   timeout      sticky: no edge arrived within 2^CNT_W-1 clocks

module prescale_period_meter #(
  parameter int CNT_W       = 24,
  parameter int AVG_LOG2    = 2,
  parameter int MIN_PERIOD  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prescaled,
  input  logic             enable,
  input  logic             periodAck,
  output logic [CNT_W-1:0] period,
  output logic             periodValid,
  output logic             overrun,
  output logic             timeout
);

  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int NPER_W = AVG_LOG2 + 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W:0]    MIN_P     = (CNT_W+1)'(MIN_PERIOD);
  // nper value at which the next accepted edge completes an average
  localparam logic [NPER_W-1:0] NPER_LAST = NPER_W'((1 << AVG_LOG2) - 1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [NPER_W-1:0] nper_q, nper_d;

  logic [CNT_W-1:0] period_d;
  logic             valid_d;
  logic             overrun_d;
  logic             timeout_d;

  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] sample;
  logic [ACC_W-1:0] acc_sum;
  logic             accepted;
  logic             new_result;

  // Synchroniser and edge detector run independently of enable so that the
  // first rise after enabling is seen cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], prescaled};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      nper_q      <= '0;
      period      <= '0;
      periodValid <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      nper_q      <= nper_d;
      period      <= period_d;
      periodValid <= valid_d;
      overrun     <= overrun_d;
      timeout     <= timeout_d;
    end
  end

  // The sample for the closing edge is cnt+1; a counter already at its
  // maximum is a timeout, never a sample, so the sample always fits CNT_W.
  assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
  assign sample   = cnt_inc[CNT_W-1:0];
  assign acc_sum  = acc_q + ACC_W'(sample);
  assign accepted = (state_q == MEASURE) && rise && (cnt_inc >= MIN_P) &&
                    (cnt_q != CNT_MAX);
  assign new_result = enable && accepted && (nper_q == NPER_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    nper_d    = nper_q;
    timeout_d = timeout;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      nper_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d  = '0;
          acc_d  = '0;
          nper_d = '0;
          if (rise) begin
            state_d   = MEASURE;
            timeout_d = 1'b0;
          end
        end
        MEASURE: begin
          if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
            acc_d     = '0;
            nper_d    = '0;
          end else if (accepted) begin
            // the closing edge of one period opens the next, so no gap
            cnt_d = '0;
            if (nper_q == NPER_LAST) begin
              acc_d  = '0;
              nper_d = '0;
            end else begin
              acc_d  = acc_sum;
              nper_d = nper_q + NPER_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
          nper_d  = '0;
        end
      endcase
    end
  end

  // Handshake: a result coinciding with an ack is a clean hand-over, not an
  // overrun; ack with nothing pending leaves everything as is.
  always_comb begin
    period_d  = period;
    valid_d   = periodValid;
    overrun_d = overrun;

    if (new_result) begin
      period_d = CNT_W'(acc_sum >> AVG_LOG2);
      valid_d  = 1'b1;
      if (periodValid && !periodAck) begin
        overrun_d = 1'b1;
      end else if (periodAck) begin
        overrun_d = 1'b0;
      end
    end else if (periodAck) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_prescale_period_meter.sv
// tb/tb_prescale_period_meter.sv - self-checking bench for prescale_period_meter

module tb_prescale_period_meter;

  logic clk = 1'b0;
  logic reset;
  logic prescaled;
  logic enable;

  logic        auto_a = 1'b1;
  logic        auto_b = 1'b1;
  logic        mon_ack_a = 1'b0;
  logic        mon_ack_b = 1'b0;
  logic        man_ack_a = 1'b0;
  logic        ack_a, ack_b;

  logic [15:0] period_a;
  logic        valid_a, overrun_a, timeout_a;
  logic [7:0]  period_b;
  logic        valid_b, overrun_b, timeout_b;

  assign ack_a = auto_a ? mon_ack_a : man_ack_a;
  assign ack_b = auto_b ? mon_ack_b : 1'b0;

  prescale_period_meter #(
    .CNT_W(16), .AVG_LOG2(0), .MIN_PERIOD(8), .SYNC_STAGES(2)
  ) dut_a (
    .clk(clk), .reset(reset), .prescaled(prescaled), .enable(enable),
    .periodAck(ack_a), .period(period_a), .periodValid(valid_a),
    .overrun(overrun_a), .timeout(timeout_a)
  );

  prescale_period_meter #(
    .CNT_W(8), .AVG_LOG2(2), .MIN_PERIOD(8), .SYNC_STAGES(2)
  ) dut_b (
    .clk(clk), .reset(reset), .prescaled(prescaled), .enable(enable),
    .periodAck(ack_b), .period(period_b), .periodValid(valid_b),
    .overrun(overrun_b), .timeout(timeout_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int nres_b  = 0;

  int qa[$];
  int qb[$];

  // edge model for dut_a: every rise closes the previous spacing
  logic model_on = 1'b0;
  logic open     = 1'b0;
  int   cur_s    = 0;

  typedef struct {
    int sp[4];
    int avg;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_rise(input int s);
    if (model_on && open && cur_s >= 8) qa.push_back(cur_s);
    open  = 1'b1;
    cur_s = s;
  endtask

  task automatic one_period(input int s);
    model_rise(s);
    prescaled = 1'b1;
    tick(s / 2);
    prescaled = 1'b0;
    tick(s - s / 2);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (qa.size() != 0 || qb.size() != 0); i++) tick(1);
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
    qa.delete();
    qb.delete();
  endtask

  task automatic clean();
    drain();
    enable    = 1'b0;
    prescaled = 1'b0;
    tick(3);
    open   = 1'b0;
    enable = 1'b1;
    tick(2);
  endtask

  // auto-ack scoreboard monitors
  always @(negedge clk) begin
    if (auto_a && valid_a && !mon_ack_a) begin
      if (qa.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_result: got period %0d expected none", period_a);
      end else begin
        check("a_period", period_a, qa.pop_front());
        check("a_overrun", overrun_a, 0);
      end
      mon_ack_a = 1'b1;
    end else begin
      mon_ack_a = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (auto_b && valid_b && !mon_ack_b) begin
      nres_b++;
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_result: got period %0d expected none", period_b);
      end else begin
        check("b_period", period_b, qb.pop_front());
      end
      mon_ack_b = 1'b1;
    end else begin
      mon_ack_b = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tw;

    tbl[0].sp = '{100, 101, 102, 103}; tbl[0].avg = 101;
    tbl[1].sp = '{8, 9, 10, 11};       tbl[1].avg = 9;
    tbl[2].sp = '{200, 201, 202, 203}; tbl[2].avg = 201;
    tbl[3].sp = '{60, 61, 61, 61};     tbl[3].avg = 60;

    reset     = 1'b1;
    enable    = 1'b0;
    prescaled = 1'b0;
    tick(3);
    check("rst_period_a", period_a, 0);
    check("rst_valid_a", valid_a, 0);
    check("rst_overrun_a", overrun_a, 0);
    check("rst_timeout_a", timeout_a, 0);
    check("rst_period_b", period_b, 0);
    check("rst_valid_b", valid_b, 0);
    reset = 1'b0;
    tick(2);

    // steady 100-clock wave, one result per period on dut_a
    enable   = 1'b1;
    model_on = 1'b1;
    tick(2);
    repeat (4) one_period(100);
    check("b_no_result_before_4", nres_b, 0);
    clean();

    // table of four-spacing averages
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 0 && i > 0) qb.push_back(tbl[i-1].avg);
        one_period(tbl[i].sp[j]);
      end
    end
    qb.push_back(tbl[3].avg);
    one_period(50);
    check("b_result_count", nres_b, 4);
    clean();

    // glitch 3 clocks after an accepted edge is ignored
    one_period(100);
    model_rise(100);
    prescaled = 1'b1; tick(1);
    prescaled = 1'b0; tick(2);
    prescaled = 1'b1; tick(2);
    prescaled = 1'b0; tick(95);
    one_period(60);
    clean();

    // overrun and same-cycle ack on dut_a
    auto_a   = 1'b0;
    model_on = 1'b0;
    one_period(100);
    one_period(120);
    prescaled = 1'b1; tick(25);
    prescaled = 1'b0; tick(20);
    check("ovr_period", period_a, 120);
    check("ovr_overrun", overrun_a, 1);
    check("ovr_valid", valid_a, 1);
    man_ack_a = 1'b1; tick(1);
    man_ack_a = 1'b0;
    check("ack_valid_clr", valid_a, 0);
    check("ack_overrun_clr", overrun_a, 0);
    tick(4);
    one_period(80);
    check("pre_same_valid", valid_a, 1);
    check("pre_same_period", period_a, 50);
    qb.push_back(87);
    prescaled = 1'b1;
    tick(2);
    man_ack_a = 1'b1;
    tick(1);
    man_ack_a = 1'b0;
    check("same_period", period_a, 80);
    check("same_valid", valid_a, 1);
    check("same_overrun", overrun_a, 0);
    tick(1);
    check("same_valid_hold", valid_a, 1);
    tick(36);
    prescaled = 1'b0;
    tick(10);

    // asynchronous reset mid-period with a pending result
    #2;
    reset = 1'b1;
    #1;
    check("async_period_a", period_a, 0);
    check("async_valid_a", valid_a, 0);
    check("async_overrun_a", overrun_a, 0);
    check("async_period_b", period_b, 0);
    #3;
    reset = 1'b0;
    tick(2);
    check("post_rst_valid_a", valid_a, 0);
    qb.delete();
    open     = 1'b0;
    auto_a   = 1'b1;
    model_on = 1'b1;

    // enable dropped mid-average discards the partial sum
    repeat (3) one_period(60);
    enable = 1'b0;
    tick(3);
    open   = 1'b0;
    enable = 1'b1;
    tick(2);
    repeat (4) one_period(100);
    qb.push_back(100);
    one_period(100);
    clean();

    // timeout on dut_b (CNT_W=8) and restart
    auto_a   = 1'b0;
    model_on = 1'b0;
    one_period(50);
    tick(150);
    check("to_early", timeout_b, 0);
    tw = 0;
    for (int i = 0; i < 100 && !timeout_b; i++) begin
      tick(1);
      tw++;
    end
    check("to_set", timeout_b, 1);
    check("to_window", (200 + tw >= 250 && 200 + tw <= 265), 1);
    check("to_period_kept", period_b, 100);
    check("to_valid", valid_b, 0);
    prescaled = 1'b1;
    tick(5);
    check("to_clear_on_edge", timeout_b, 0);
    tick(20);
    prescaled = 1'b0;
    tick(25);
    repeat (3) one_period(50);
    qb.push_back(50);
    one_period(50);
    drain();
    check("restart_period_b", period_b, 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prescale_period_meter.md
# prescale_period_meter

Measures the period of the divided-down square wave from the prescaler stage, in system-clock cycles, so the DSP/control logic can derive string frequency. Sits between the prescaler output (asynchronous to the system clock) and the register/AXI side of myDSP: it synchronises the input, detects rising edges, averages 2^AVG_LOG2 periods and presents the result through a valid/ack handshake with overrun and timeout flags.

## Interface
- CNT_W, 24: width of the period counter and of `period`.
- AVG_LOG2, 2: log2 of the number of periods averaged per result (0 = every period).
- MIN_PERIOD, 8: minimum accepted edge spacing in clocks; closer edges are rejected as glitches.
- SYNC_STAGES, 2: synchroniser depth for `prescaled` (≥2).

- clk, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- prescaled, in, 1: prescaler output square wave, asynchronous to `clk`.
- enable, in, 1: measurement enable.
- periodAck, in, 1: consumer acknowledges `period`.
- period, out, CNT_W: averaged period in clocks.
- periodValid, out, 1: `period` holds an unacknowledged result.
- overrun, out, 1: sticky; a result was overwritten before being acked.
- timeout, out, 1: sticky; no edge arrived within 2^CNT_W−1 clocks.

## Operation
- Synchroniser: SYNC_STAGES flops, then one `prev` flop. `rise = sync & ~prev`. The synchroniser runs regardless of `enable`.
- States: IDLE, MEASURE.
- IDLE: `cnt`, `acc` and `nper` are held at 0. On `rise` with `enable`=1: go to MEASURE, `cnt`←0, and clear `timeout`.
- MEASURE, every clock: `cnt`←`cnt`+1.
  - On `rise` with `cnt+1` ≥ MIN_PERIOD (accepted edge), the measured sample is `cnt+1`. Then `acc`←`acc`+sample, `nper`←`nper`+1, and `cnt`←0.
  - On `rise` with `cnt+1` < MIN_PERIOD: ignored; `cnt` keeps counting.
  - When `nper` reaches 2^AVG_LOG2 on an accepted edge: `period`←(`acc`+sample)>>AVG_LOG2 (truncated), then `acc`←0 and `nper`←0. Measurement continues without a gap; the closing edge opens the next period.
  - If `cnt` reaches 2^CNT_W−1 with no accepted edge: `timeout`←1, go to IDLE, clear `acc` and `nper`. `period` is unchanged and no result is issued.
- `enable` low in any state: go to IDLE next clock and discard partial `acc`/`nper`. The handshake outputs are unaffected.
- Widths:
  - `acc` is CNT_W+AVG_LOG2 bits and cannot overflow, because each sample is ≤ 2^CNT_W−1.
  - `nper` is AVG_LOG2+1 bits.
- Handshake:
  - A new result sets `periodValid`=1.
  - `periodValid` clears on a clock where `periodAck`=1 and no new result is produced.
  - A new result in the same clock as `periodAck`: the new value is loaded, `periodValid` stays 1, and `overrun` is not set.
  - A new result while `periodValid`=1 and `periodAck`=0: `period` is overwritten and `overrun`←1.
  - `overrun` clears on `periodAck`=1, unless a new overrun occurs in that same clock.
  - `periodAck` while `periodValid`=0 has no effect.

## Timing
- Reset values: state IDLE, `period`=0, `periodValid`=0, `overrun`=0, `timeout`=0, `cnt`=`acc`=`nper`=0, and synchroniser flops and `prev` = 0.
- Reset mid-measurement aborts immediately and asynchronously. After release, the first `rise` is needed before counting resumes.
- Input-to-`rise` latency: SYNC_STAGES clocks after the first clock edge that samples `prescaled` high.
- Result latency: `period`/`periodValid` update on the clock edge following the closing `rise` cycle, i.e. registered with 1 clock latency.
- Sample definition: rises in clock cycles t0 and t1 give sample t1−t0.
- Input requirements: the `prescaled` high and low phases must each be ≥ SYNC_STAGES+1 clocks. Narrower pulses may be missed, which is acceptable.

## Test plan
- CNT_W=16, AVG_LOG2=0, MIN_PERIOD=8: after reset, drive `prescaled` with a period of 100 clocks (50 high / 50 low) and ack each result → the first `periodValid` after the 2nd edge gives `period`=100. Every later result is 100, with `overrun`=0.
- AVG_LOG2=2: drive edge spacings of 100, 101, 102, 103 → one result, `period`=101 (406>>2). No result is produced after fewer than 4 periods.
- Hold `periodAck`=0 across two results (spacing 100, then 120) → `period`=120, `overrun`=1, `periodValid`=1. Pulse `periodAck` one clock → `periodValid`=0 and `overrun`=0. Also assert `periodAck` in exactly the result cycle → `periodValid` stays 1 and `overrun` stays 0.
- MIN_PERIOD=8: insert a 2-clock-wide pulse whose rise lands 3 clocks after an accepted edge, and place the next real edge 100 clocks after the accepted edge → the glitch is ignored and `period`=100.
- CNT_W=8: stop `prescaled` after one edge → `timeout`=1 after 255 clocks, state IDLE, `period` unchanged. Restart with spacing 50 → `timeout` clears at the first edge, then `period`=50.
- Assert `reset` asynchronously mid-period with `periodValid`=1 → all outputs are 0 immediately. Drop `enable` mid-average → the partial sum is discarded, and after re-enable the first result covers only fresh periods.
